// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced LSB-first over WIDTH bits.
// Optional subtract mode enabled by defining SERIAL_ADD_SUB_EN (adds the 'sub' port).
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_last;
    logic               w_s;
    logic               w_cy;
    logic               w_busy_d;
    logic               w_done_d;
    logic [WIDTH-1:0]   w_b_cap;
    logic               w_c_cap;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_s      = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_cy     = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);

`ifdef SERIAL_ADD_SUB_EN
    // Subtract as a + ~b + 1; cin is ignored in that mode.
    assign w_b_cap = sub ? ~b : b;
    assign w_c_cap = sub ? 1'b1 : cin;
`else
    assign w_b_cap = b;
    assign w_c_cap = cin;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; any unused encoding falls back to IDLE
    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_next = start  ? S_RUN  : S_IDLE;
            S_RUN:   w_state_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_next = start  ? S_RUN  : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so busy/done come straight from flops
    always_comb begin
        w_busy_d = 1'b0;
        w_done_d = 1'b0;
        case (w_state_next)
            S_RUN:   w_busy_d = 1'b1;
            S_DONE:  w_done_d = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, serial add, result hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= w_busy_d;
            r_done <= w_done_d;
            if (w_accept) begin
                r_a_sh  <= a;
                r_b_sh  <= w_b_cap;
                r_carry <= w_c_cap;
                r_cnt   <= '0;
                r_sum   <= '0;
            end else if (r_state == S_RUN) begin
                r_carry <= w_cy;
                r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                r_a_sh  <= r_a_sh >> 1;
                r_b_sh  <= r_b_sh >> 1;
                r_cnt   <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_cout <= w_cy;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8); subtract vectors
// run only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_total = 0;
    int n_pass  = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation: start for one edge, optional extra start pulse at RUN cycle ign_at.
    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ic, input logic [7:0] es, input logic ec, input int ign_at);
        int cyc;
        int n_busy;
        int n_done;
        start = 1'b1; a = ia; b = ib; cin = ic;
        tick();
        start = 1'b0;
        a = 8'h00; b = 8'h00; cin = 1'b0;
        cyc = 1; n_busy = 0; n_done = 0;
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        if (busy) n_busy++;
        while (!done && cyc < 20) begin
            if (cyc == ign_at) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
            if (busy) n_busy++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        chk({tag, "_done_cycle"}, 32'(cyc), 32'd9);
        chk({tag, "_busy_cycles"}, 32'(n_busy), 32'd8);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        // Pulse must be single and the result must hold afterwards
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) n_done++;
        end
        chk({tag, "_single_done"}, 32'(n_done), 32'd0);
        chk({tag, "_sum_hold"}, 32'(sum), 32'(es));
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int n_busy;
        int n_done;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
        run_op("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        run_op("t2b", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0);
        run_op("t3", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 3);

        // Back-to-back with start held high
        start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("t4_first_done", 32'(done), 32'd1);
        for (int op = 0; op < 3; op++) begin
            chk("t4_sum",  32'(sum),  32'd0);
            chk("t4_cout", 32'(cout), 32'd1);
            chk("t4_busy_in_done", 32'(busy), 32'd0);
            cyc = 0; n_busy = 0;
            do begin
                tick();
                cyc++;
                if (busy) n_busy++;
            end while (!done && cyc < 20);
            chk("t4_period", 32'(cyc), 32'd9);
            chk("t4_busy_cycles", 32'(n_busy), 32'd8);
        end
        start = 1'b0;
        tick();
        tick();

        // Asynchronous abort mid-RUN
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("t5_busy_before", 32'(busy), 32'd1);
        chk("t5_cout_before", 32'(cout), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy_rst", 32'(busy), 32'd0);
        chk("t5_done_rst", 32'(done), 32'd0);
        chk("t5_sum_rst",  32'(sum),  32'd0);
        chk("t5_cout_rst", 32'(cout), 32'd0);
        n_done = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (done || busy) n_done++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) n_done++;
        end
        chk("t5_no_done", 32'(n_done), 32'd0);
        run_op("t5_new", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        run_op("t6a", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 0);
        run_op("t6b", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 0);
        sub = 1'b0;
        run_op("t6c", 8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
